// File: rtl/f2_exhaustive_tester.sv
// On-chip exhaustive tester for the 6-input f2 block: walks every input vector in
// binary-count order, captures the responses and compares them with a golden truth table.
module f2_exhaustive_tester #(
  parameter int                    N_IN     = 6,
  parameter int                    SETTLE   = 1,
  parameter logic [2**N_IN-1:0]    EXPECTED = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      pattern,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic [2**N_IN-1:0]   truth_table
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [N_IN-1:0]  r_pattern, w_pattern;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic [N_IN:0]    r_fail_count, w_fail_count;
  logic [N_IN-1:0]  r_first_fail_idx, w_first_fail_idx;
  logic [NV-1:0]    r_truth_table, w_truth_table;
  logic [CW-1:0]    r_settle, w_settle;
  logic             w_mismatch;

  assign w_mismatch = (dut_out != EXPECTED[r_pattern]);

  // NOTE: the whole capture vector sits on the async reset; it is a result
  // register read directly at the port, not a RAM, so clearing it is cheap and required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_pattern        <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail_count     <= '0;
      r_first_fail_idx <= '0;
      r_truth_table    <= '0;
      r_settle         <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values.
      r_state          <= w_state;
      r_pattern        <= w_pattern;
      r_busy           <= w_busy;
      r_done           <= w_done;
      r_pass           <= w_pass;
      r_fail_count     <= w_fail_count;
      r_first_fail_idx <= w_first_fail_idx;
      r_truth_table    <= w_truth_table;
      r_settle         <= w_settle;
    end
  end

  always_comb begin
    // NOTE: hold-current defaults first, so no path through the case infers a latch.
    w_state          = r_state;
    w_pattern        = r_pattern;
    w_busy           = r_busy;
    w_done           = 1'b0;
    w_pass           = r_pass;
    w_fail_count     = r_fail_count;
    w_first_fail_idx = r_first_fail_idx;
    w_truth_table    = r_truth_table;
    w_settle         = r_settle;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state          = S_HOLD;
          w_pattern        = '0;
          w_busy           = 1'b1;
          w_fail_count     = '0;
          w_first_fail_idx = '0;
          w_truth_table    = '0;
          w_pass           = 1'b0;
          w_settle         = CW'(SETTLE);
        end
      end

      S_HOLD: begin
        if (r_settle != '0) begin
          w_settle = r_settle - 1'b1;
        end else begin
          w_truth_table[r_pattern] = dut_out;
          if (w_mismatch) begin
            w_fail_count = r_fail_count + 1'b1;
            if (r_fail_count == '0) w_first_fail_idx = r_pattern;
          end
          if (&r_pattern) begin
            // Final vector: the verdict must include this sample's mismatch too.
            w_state   = S_DONE;
            w_busy    = 1'b0;
            w_done    = 1'b1;
            w_pattern = '0;
            w_pass    = (r_fail_count == '0) && !w_mismatch;
          end else begin
            w_pattern = r_pattern + 1'b1;
            w_settle  = CW'(SETTLE);
          end
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign pattern        = r_pattern;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign fail_count     = r_fail_count;
  assign first_fail_idx = r_first_fail_idx;
  assign truth_table    = r_truth_table;

endmodule

// File: tb/tb_f2_exhaustive_tester.sv
// Scoreboard bench for f2_exhaustive_tester: directed runs with hand-computed verdicts
// on a SETTLE=1 instance, plus a continuous-start run on a SETTLE=0 instance.
module tb_f2_exhaustive_tester;

  localparam logic [63:0] E  = 64'hF0F0_0000_FFFF_0001;
  localparam logic [63:0] E0 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  // SETTLE=1 instance
  logic        start;
  logic [5:0]  pattern;
  logic        dut_out;
  logic        busy, done, pass;
  logic [6:0]  fail_count;
  logic [5:0]  first_fail_idx;
  logic [63:0] truth_table;

  // SETTLE=0 instance
  logic        start0;
  logic [5:0]  pattern0;
  logic        dut_out0;
  logic        busy0, done0, pass0;
  logic [6:0]  fail_count0;
  logic [5:0]  first_fail_idx0;
  logic [63:0] truth_table0;

  logic [63:0] gold  = E;
  logic [63:0] gold0 = E0;
  int          mode  = 0;   // 0 golden, 1 flipped at vector 37, 2 tied low

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    int          t0;
    logic        pass;
    logic [6:0]  fc;
    logic [5:0]  ffi;
    logic [63:0] tt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dut_out  = (mode == 2) ? 1'b0 : (gold[pattern] ^ ((mode == 1) && (pattern == 6'd37)));
  assign dut_out0 = gold0[pattern0];

  f2_exhaustive_tester #(.N_IN(6), .SETTLE(1), .EXPECTED(E)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .truth_table(truth_table)
  );

  f2_exhaustive_tester #(.N_IN(6), .SETTLE(0), .EXPECTED(E0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .pattern(pattern0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fail_count0),
    .first_fail_idx(first_fail_idx0), .truth_table(truth_table0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the SETTLE=1 instance: pattern timing every cycle, verdict on done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && q.size() > 0)
        check("pattern_seq", 64'(pattern), 64'((cyc - q[0].t0) / 2));
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("done_cycle",     64'(cyc),            64'(mon_e.t0 + 128));
          check("pass",           64'(pass),           64'(mon_e.pass));
          check("fail_count",     64'(fail_count),     64'(mon_e.fc));
          check("first_fail_idx", 64'(first_fail_idx), 64'(mon_e.ffi));
          check("truth_table",    truth_table,         mon_e.tt);
          check("busy_at_done",   64'(busy),           64'd0);
        end
      end
    end
  end

  // Monitor for the SETTLE=0 instance.
  int         t0_0       = 0;
  int         n_done0    = 0;
  logic       prev_busy0 = 1'b0;
  logic [5:0] prev_pat0  = '0;
  logic       after_done0 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy0 && prev_busy0)  check("pattern0_step",  64'(pattern0), 64'(prev_pat0) + 64'd1);
      if (busy0 && !prev_busy0) check("pattern0_first", 64'(pattern0), 64'd0);
      if (after_done0) begin
        check("pass0_hold", 64'(pass0),       64'd1);
        check("fc0_hold",   64'(fail_count0), 64'd0);
        after_done0 = 1'b0;
      end
      if (done0) begin
        check("done0_cycle", 64'(cyc), 64'(t0_0 + 64 + 66 * n_done0));
        check("pass0",       64'(pass0),       64'd1);
        check("fail_count0", 64'(fail_count0), 64'd0);
        check("truth0",      truth_table0,     E0);
        n_done0++;
        after_done0 = 1'b1;
      end
      prev_busy0 = busy0;
      prev_pat0  = pattern0;
    end
  end

  task automatic run_start(input int m, input logic p, input logic [6:0] fc,
                           input logic [5:0] ffi, input logic [63:0] tt);
    exp_t e;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  64'(busy),           64'd1);
    check("start_pat",   64'(pattern),        64'd0);
    check("start_fc",    64'(fail_count),     64'd0);
    check("start_ffi",   64'(first_fail_idx), 64'd0);
    check("start_tt",    truth_table,         64'd0);
    check("start_pass",  64'(pass),           64'd0);
    e.t0 = cyc; e.pass = p; e.fc = fc; e.ffi = ffi; e.tt = tt;
    q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("timeout_idle", 64'(busy), 64'd0);
    check("sb_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pattern"}, 64'(pattern),        64'd0);
    check({tag, "_busy"},    64'(busy),           64'd0);
    check({tag, "_done"},    64'(done),           64'd0);
    check({tag, "_pass"},    64'(pass),           64'd0);
    check({tag, "_fc"},      64'(fail_count),     64'd0);
    check({tag, "_ffi"},     64'(first_fail_idx), 64'd0);
    check({tag, "_tt"},      truth_table,         64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_busy0", 64'(busy0),    64'd0);
    check("reset_pat0",  64'(pattern0), 64'd0);
    rst_n = 1'b1;

    // Golden response.
    run_start(0, 1'b1, 7'd0, 6'd0, E);
    wait_idle(300);

    // Response inverted only at vector 37.
    run_start(1, 1'b0, 7'd1, 6'd37, E ^ (64'd1 << 37));
    wait_idle(300);

    // Response tied low: 25 ones in E (8 + 0 + 16 + 1), first at vector 0.
    run_start(2, 1'b0, 7'd25, 6'd0, 64'd0);
    wait_idle(300);
    check("idle_pass_hold", 64'(pass),       64'd0);
    check("idle_fc_hold",   64'(fail_count), 64'd25);

    // start re-pulsed at vectors 5 and 40 must be ignored.
    run_start(0, 1'b1, 7'd0, 6'd0, E);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (69) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(300);

    // Reset during vector 20 of a failing run.
    run_start(2, 1'b0, 7'd25, 6'd0, 64'd0);
    repeat (40) @(negedge clk);
    check("pre_reset_pat", 64'(pattern), 64'd20);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    q.delete();
    repeat (3) @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    repeat (140) @(negedge clk);
    check("post_reset_idle", 64'(busy), 64'd0);
    run_start(0, 1'b1, 7'd0, 6'd0, E);
    wait_idle(300);

    // SETTLE=0 instance with start held for 200 edges: runs at T0, +66, +132, +198.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    t0_0 = cyc;
    repeat (199) @(negedge clk);
    start0 = 1'b0;
    begin
      int n = 0;
      while ((busy0 || done0) && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) check("timeout_idle0", 64'(busy0), 64'd0);
    end
    @(negedge clk);
    check("done0_count", 64'(n_done0), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
